side_buffer: RTL
================

Name: side_buffer

Overview:
- Small FIFO that holds flits the router removes from the ring under deflection pressure.
- Feeds the injector stage as its `crinject` source; sits directly upstream of the injector.
- Presents the oldest buffered flit for re-injection (first-word-fall-through).
- Tracks how long the head flit has waited; past a threshold it raises a redirect request that forces a slot open.

Parameters:
- FLIT_W, 11, flit width (matches the router's address/flit bus).
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles of a valid-but-not-taken head flit before redirect asserts; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- buf_in  input  FLIT_W  flit removed from the router, to be buffered.
- buf_in_valid  input  1  buf_in holds a flit this cycle.
- buf_full  output  1  FIFO cannot accept a push this cycle unless a pop also occurs.
- crinject  output  FLIT_W  head flit offered to the injector; all-zero when empty.
- crinject_valid  output  1  crinject holds a real flit.
- crinject_taken  input  1  injector placed crinject into a free slot this cycle.
- redirect  output  1  request to the injector to force-eject a ring flit into this buffer, freeing a slot.
- overflow  output  1  sticky: a push was dropped.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release on next clk edge):
  - Pointers and count are 0; crinject is 0.
  - crinject_valid, buf_full, redirect and overflow are 0.
  - Starvation counter is 0.
- Storage:
  - Circular array with read/write pointers of clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - count is a separate register.
- Output is combinational from registered state:
  - crinject = mem[rd_ptr] when count != 0, else 0.
  - crinject_valid = (count != 0).
  - buf_full = (count == DEPTH).
- pop = crinject_taken && crinject_valid.
  - crinject_taken while empty is ignored and has no state effect.
- push = buf_in_valid && (!buf_full || pop).
  - Push while full is accepted only when a pop occurs in the same cycle.
- Drop rule: buf_in_valid && buf_full && !pop drops the flit and sets overflow. overflow stays 1 until rst.
- Update on clk:
  - push: mem[wr_ptr] <= buf_in, wr_ptr+1.
  - pop: rd_ptr+1.
  - count += push - pop.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - A flit pushed into an empty buffer appears on crinject the cycle after the push edge.
  - No same-cycle bypass.
- Starvation counter (width clog2(STARVE_LIMIT+1)), evaluated each clk:
  - If pop, or count == 0: counter <= 0.
  - Else if crinject_valid && !crinject_taken && counter < STARVE_LIMIT: counter+1.
  - The counter saturates at STARVE_LIMIT.
- redirect is registered:
  - Sets when the counter reaches STARVE_LIMIT.
  - Clears on the edge where a pop occurs, or when count becomes 0.
  - redirect = 1 implies crinject_valid = 1.
- Simultaneous push and pop with count == 1:
  - The head advances to the new flit.
  - The starvation counter resets, since the new head has not waited.
- Reset mid-operation discards all buffered flits immediately. No partial output is held.
- Order is strict FIFO. Flit contents pass through unmodified.

Decomposition:
- Shared router package holds:
  - FLIT_W.
  - Port index constants (0 east, 1 west, 2 north, 3 south).
  - An `empty flit` constant of all zeros.
- One natural sub-module: sb_starve_ctr. It contains the saturating starvation counter and the redirect flag, with inputs valid, taken and empty.
- FIFO storage and pointers stay in side_buffer.

Test Plan:
- Reset, then push 11'b00000000101:
  - Count goes 0->1.
  - Next cycle crinject = 00000000101, crinject_valid = 1, redirect = 0.
- Push 4 flits 0x021, 0x027, 0x02C, 0x011 with no takes:
  - buf_full = 1, count = 4.
  - A 5th push of 0x03C sets overflow = 1 and is dropped.
  - Taking all four returns 0x021, 0x027, 0x02C, 0x011 in order.
- Buffer full plus simultaneous push 0x00C and take:
  - Push is accepted, count stays 4, overflow stays 0.
  - The last flit out after draining is 0x00C.
- One flit held, crinject_taken = 0 for 8 cycles:
  - redirect rises on the edge after the 8th waiting cycle.
  - Asserting crinject_taken clears redirect on the next edge, with count 1->0.
- crinject_taken = 1 while empty:
  - No pointer movement, count stays 0, crinject = 0.
- Assert rst asynchronously with count = 3 and redirect = 1:
  - count, crinject_valid and redirect go to 0 immediately.
  - After release, a push of 0x008 is the first flit out.

Source files
------------

// File: rtl/side_buffer_pkg.sv
// Shared router definitions: flit width, port indices and the empty-flit constant
// used by the side buffer and its neighbours.
package side_buffer_pkg;

  localparam int FLIT_W = 11;

  localparam int PORT_EAST  = 0;
  localparam int PORT_WEST  = 1;
  localparam int PORT_NORTH = 2;
  localparam int PORT_SOUTH = 3;

  typedef logic [FLIT_W-1:0] flit_t;

  localparam flit_t EMPTY_FLIT = '0;

endpackage

// File: rtl/sb_starve_ctr.sv
// Saturating wait counter for the head flit of the side buffer, plus the
// registered redirect request raised once the head has waited STARVE_LIMIT cycles.
module sb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic taken,
  input  logic empty,
  output logic redirect
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] ctr_q, ctr_d;
  logic          redirect_q, redirect_d;
  logic          pop;

  always_comb begin
    pop        = valid && taken;
    ctr_d      = ctr_q;
    redirect_d = redirect_q;
    if (pop || empty) begin
      // A departing head or an empty buffer means nothing is waiting any more.
      ctr_d      = '0;
      redirect_d = 1'b0;
    end else begin
      if (valid && !taken && (ctr_q < LIMIT)) begin
        ctr_d = ctr_q + SW'(1);
      end
      if (ctr_d == LIMIT) begin
        redirect_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      redirect_q <= redirect_d;
    end
  end

  assign redirect = redirect_q;

endmodule

// File: rtl/side_buffer.sv
// First-word-fall-through FIFO for flits deflected off the ring; offers the oldest
// flit to the injector and requests a forced slot when that flit starves.
module side_buffer
  import side_buffer_pkg::*;
#(
  parameter int FLIT_W       = side_buffer_pkg::FLIT_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          buf_in,
  input  logic                       buf_in_valid,
  output logic                       buf_full,
  output logic [FLIT_W-1:0]          crinject,
  output logic                       crinject_valid,
  input  logic                       crinject_taken,
  output logic                       redirect,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              empty, pop, push;

  assign empty          = (count_q == '0);
  assign crinject_valid = !empty;
  assign buf_full       = (count_q == FULL_CNT);
  assign crinject       = empty ? EMPTY_FLIT[FLIT_W-1:0] : mem_q[rd_ptr_q];
  assign count          = count_q;
  assign overflow       = overflow_q;

  assign pop  = crinject_taken && crinject_valid;
  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign push = buf_in_valid && (!buf_full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (buf_in_valid && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= buf_in;
  end

  sb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .valid    (crinject_valid),
    .taken    (crinject_taken),
    .empty    (empty),
    .redirect (redirect)
  );

endmodule
